// File: rtl/go_lite_pkg.sv
// Shared definitions for the Xillybus Lite register blocks: window layout,
// register offsets and the bit positions of the CTRL and STATUS registers.
package go_lite_pkg;

   localparam int unsigned DATA_W        = 32;
   localparam int unsigned WORD_AW       = 10;
   localparam int unsigned BASE_WORD_DEF = 768;
   localparam int unsigned CNT_W         = 9;

   typedef enum logic [1:0] {
      REG_STATUS = 2'd0,
      REG_DATA   = 2'd1,
      REG_CTRL   = 2'd2,
      REG_DROPS  = 2'd3
   } reg_off_e;

   localparam int unsigned CTRL_IRQ_EN  = 0;
   localparam int unsigned CTRL_CLR_OVF = 1;
   localparam int unsigned CTRL_FLUSH   = 2;

   localparam int unsigned ST_COUNT_LSB = 0;
   localparam int unsigned ST_EMPTY     = 16;
   localparam int unsigned ST_FULL      = 17;
   localparam int unsigned ST_OVF       = 18;
   localparam int unsigned ST_IRQ_EN    = 19;

   function automatic logic [DATA_W-1:0] status_word(input logic [CNT_W-1:0] cnt,
                                                     input logic empty,
                                                     input logic full,
                                                     input logic ovf,
                                                     input logic irq_en);
      logic [DATA_W-1:0] w;
      w                               = '0;
      w[ST_COUNT_LSB +: CNT_W]        = cnt;
      w[ST_EMPTY]                     = empty;
      w[ST_FULL]                      = full;
      w[ST_OVF]                       = ovf;
      w[ST_IRQ_EN]                    = irq_en;
      return w;
   endfunction

endpackage

// File: rtl/go_event_mailbox_if.sv
// Lite register bus plus the producer event handshake of the event mailbox.
interface go_event_mailbox_if;
   import go_lite_pkg::*;

   logic [DATA_W-1:0] user_addr;
   logic              user_wren;
   logic [3:0]        user_wstrb;
   logic [DATA_W-1:0] user_wr_data;
   logic              user_rden;
   logic [DATA_W-1:0] user_rd_data;
   logic              rd_hit;
   logic              user_irq;
   logic              ev_valid;
   logic [DATA_W-1:0] ev_data;
   logic              ev_ready;

   modport master (
      output user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
      output ev_valid, ev_data,
      input  user_rd_data, rd_hit, user_irq, ev_ready
   );

   modport slave (
      input  user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
      input  ev_valid, ev_data,
      output user_rd_data, rd_hit, user_irq, ev_ready
   );

endinterface

// File: rtl/go_evt_fifo.sv
// Single-clock FIFO with distributed-RAM storage, occupancy count and a
// registered full flag; the caller guarantees no push when full, no pop when empty.
module go_evt_fifo
   import go_lite_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wr_data,
   output logic [CW-1:0]     count,
   output logic [DATA_W-1:0] head,
   output logic              full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_q, full_d;

   // Pointer and occupancy update; flush overrides any concurrent push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      full_d = (count_d == CW'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];
   assign full  = full_q;

endmodule

// File: rtl/go_event_mailbox.sv
// FPGA-to-CPU event mailbox: producers push event words into a FIFO that the
// CPU drains through a 4-word Lite register window, with a level interrupt.
module go_event_mailbox
   import go_lite_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned BASE_WORD = BASE_WORD_DEF
) (
   input  logic               user_clk,
   input  logic               arst_n,
   go_event_mailbox_if.slave  bus
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WORD_AW-1:0] word_off;
   logic               in_win;
   reg_off_e           reg_off;
   logic               rd_win, wr_win, ctrl_wr;
   logic               do_push, do_pop, flush, clr_ovf, drop;

   logic [CW-1:0]      count;
   logic [DATA_W-1:0]  head;
   logic               full;

   logic               irq_en_q, irq_en_d;
   logic               ovf_q, ovf_d;
   logic [DATA_W-1:0]  drops_q, drops_d;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;
   logic               rd_hit_q, rd_hit_d;
   logic               irq_q, irq_d;

   logic               unused_bits;
   assign unused_bits = ^{bus.user_addr[31:12], bus.user_addr[1:0],
                          bus.user_wr_data[31:3], bus.user_wstrb[3:1]};

   go_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (user_clk),
      .rst_n   (arst_n),
      .push    (do_push),
      .pop     (do_pop),
      .flush   (flush),
      .wr_data (bus.ev_data),
      .count   (count),
      .head    (head),
      .full    (full)
   );

   // Window decode, register side effects and read-data selection.
   always_comb begin
      word_off = bus.user_addr[11:2] - WORD_AW'(BASE_WORD);
      in_win   = (word_off < WORD_AW'(4));
      reg_off  = reg_off_e'(word_off[1:0]);
      rd_win   = bus.user_rden & in_win;
      wr_win   = bus.user_wren & in_win;
      ctrl_wr  = wr_win & (reg_off == REG_CTRL) & bus.user_wstrb[0];
      flush    = ctrl_wr & bus.user_wr_data[CTRL_FLUSH];
      clr_ovf  = ctrl_wr & bus.user_wr_data[CTRL_CLR_OVF];
      do_pop   = rd_win & (reg_off == REG_DATA) & (count != '0);
      do_push  = bus.ev_valid & ~full & ~flush;
      drop     = bus.ev_valid & full;

      irq_en_d = ctrl_wr ? bus.user_wr_data[CTRL_IRQ_EN] : irq_en_q;
      ovf_d    = drop | (ovf_q & ~clr_ovf);

      drops_d = drops_q;
      if (wr_win && (reg_off == REG_DROPS)) drops_d = '0;
      else if (drop && (drops_q != '1))     drops_d = drops_q + DATA_W'(1);

      irq_d    = irq_en_q & (count != '0);
      rd_hit_d = rd_win;

      rd_data_d = rd_data_q;
      if (rd_win) begin
         case (reg_off)
            REG_STATUS: rd_data_d = status_word(CNT_W'(count), (count == '0),
                                                full, ovf_q, irq_en_q);
            REG_DATA:   rd_data_d = (count != '0) ? head : '0;
            REG_CTRL:   rd_data_d = {{(DATA_W-1){1'b0}}, irq_en_q};
            REG_DROPS:  rd_data_d = drops_q;
            default:    rd_data_d = rd_data_q;
         endcase
      end
   end

   always_ff @(posedge user_clk or negedge arst_n) begin
      if (!arst_n) begin
         irq_en_q  <= 1'b0;
         ovf_q     <= 1'b0;
         drops_q   <= '0;
         rd_data_q <= '0;
         rd_hit_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         irq_en_q  <= irq_en_d;
         ovf_q     <= ovf_d;
         drops_q   <= drops_d;
         rd_data_q <= rd_data_d;
         rd_hit_q  <= rd_hit_d;
         irq_q     <= irq_d;
      end
   end

   assign bus.user_rd_data = rd_data_q;
   assign bus.rd_hit       = rd_hit_q;
   assign bus.user_irq     = irq_q;
   assign bus.ev_ready     = ~full;

endmodule

// File: tb/tb_go_event_mailbox.sv
// Directed bench for go_event_mailbox: reads queue their expected data, a
// monitor pops and compares whenever rd_hit is presented.
module tb_go_event_mailbox;
   import go_lite_pkg::*;

   localparam int unsigned BASE = 768;

   logic clk;
   logic rst_n;

   go_event_mailbox_if bus ();

   go_event_mailbox #(.DEPTH(16), .BASE_WORD(BASE)) dut (
      .user_clk (clk),
      .arst_n   (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned    n_vec;
   int unsigned    n_err;
   logic [31:0]    exp_q[$];
   string          name_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] waddr(input int unsigned off);
      return 32'((BASE + off) << 2);
   endfunction

   // All tasks start and end on a falling edge.
   task automatic rd(input int unsigned off, input logic [31:0] exp, input string name);
      bus.user_rden = 1'b1;
      bus.user_addr = waddr(off);
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(negedge clk);
      bus.user_rden = 1'b0;
   endtask

   task automatic wr(input int unsigned off, input logic [31:0] data, input logic [3:0] strb);
      bus.user_wren    = 1'b1;
      bus.user_addr    = waddr(off);
      bus.user_wr_data = data;
      bus.user_wstrb   = strb;
      @(negedge clk);
      bus.user_wren    = 1'b0;
   endtask

   task automatic push(input logic [31:0] data);
      bus.ev_valid = 1'b1;
      bus.ev_data  = data;
      @(negedge clk);
      bus.ev_valid = 1'b0;
   endtask

   // Monitor: every presented read response is checked against the queue head.
   initial begin
      logic [31:0] e;
      string       nm;
      forever begin
         @(negedge clk);
         if (bus.rd_hit === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_rd_hit: got data 0x%08h, no read expected", bus.user_rd_data);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               chk(nm, bus.user_rd_data, e);
            end
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.user_addr    = '0;
      bus.user_wren    = 1'b0;
      bus.user_wstrb   = '0;
      bus.user_wr_data = '0;
      bus.user_rden    = 1'b0;
      bus.ev_valid     = 1'b0;
      bus.ev_data      = '0;
      repeat (3) @(negedge clk);

      chk("reset_rd_data",  bus.user_rd_data, 32'h0);
      chk("reset_rd_hit",   32'(bus.rd_hit), 32'h0);
      chk("reset_irq",      32'(bus.user_irq), 32'h0);
      chk("reset_ev_ready", 32'(bus.ev_ready), 32'h1);
      rst_n = 1'b1;
      @(negedge clk);

      // Empty mailbox
      rd(REG_STATUS, 32'h0001_0000, "status_empty");
      rd(REG_DATA,   32'h0000_0000, "data_empty");
      rd(REG_STATUS, 32'h0001_0000, "status_after_empty_pop");

      // Two events, interrupt enable, drain
      push(32'hA5A5_0001);
      push(32'hA5A5_0002);
      wr(REG_CTRL, 32'h1, 4'h1);
      @(negedge clk);
      chk("irq_raised", 32'(bus.user_irq), 32'h1);
      rd(REG_STATUS, 32'h0008_0002, "status_two");
      rd(REG_DATA,   32'hA5A5_0001, "data_first");
      rd(REG_DATA,   32'hA5A5_0002, "data_second");
      chk("irq_held_at_last_pop", 32'(bus.user_irq), 32'h1);
      @(negedge clk);
      chk("irq_fell", 32'(bus.user_irq), 32'h0);
      wr(REG_CTRL, 32'h0, 4'h1);

      // Fill past full: 16 accepted, 2 dropped
      for (int i = 0; i < 18; i++) begin
         chk("ev_ready_fill", 32'(bus.ev_ready), (i < 16) ? 32'h1 : 32'h0);
         bus.ev_valid = 1'b1;
         bus.ev_data  = 32'h100 + 32'(i);
         @(negedge clk);
      end
      bus.ev_valid = 1'b0;
      chk("ev_ready_full", 32'(bus.ev_ready), 32'h0);
      rd(REG_STATUS, 32'h0006_0010, "status_full");
      rd(REG_DROPS,  32'h0000_0002, "drops_two");
      rd(REG_CTRL,   32'h0000_0000, "ctrl_irq_off");

      // Drain to 5, then push and pop every cycle
      for (int i = 0; i < 11; i++) rd(REG_DATA, 32'h100 + 32'(i), "data_drain");
      for (int k = 0; k < 8; k++) begin
         chk("ev_ready_stream", 32'(bus.ev_ready), 32'h1);
         bus.ev_valid = 1'b1;
         bus.ev_data  = 32'h200 + 32'(k);
         rd(REG_DATA, (k < 5) ? (32'h10B + 32'(k)) : (32'h200 + 32'(k - 5)), "data_stream");
      end
      bus.ev_valid = 1'b0;
      rd(REG_STATUS, 32'h0004_0005, "status_stream");

      // Clear overflow + flush together with a push
      bus.user_wren    = 1'b1;
      bus.user_addr    = waddr(REG_CTRL);
      bus.user_wr_data = 32'h6;
      bus.user_wstrb   = 4'h1;
      bus.ev_valid     = 1'b1;
      bus.ev_data      = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.user_wren = 1'b0;
      bus.ev_valid  = 1'b0;
      rd(REG_STATUS, 32'h0001_0000, "status_flushed");
      rd(REG_DATA,   32'h0000_0000, "data_flushed");
      rd(REG_DROPS,  32'h0000_0002, "drops_kept");
      wr(REG_DROPS, 32'h0, 4'h0);
      rd(REG_DROPS,  32'h0000_0000, "drops_cleared");

      // CTRL write without byte-0 strobe is ignored
      wr(REG_CTRL, 32'h1, 4'h2);
      rd(REG_CTRL, 32'h0000_0000, "ctrl_no_strobe");

      // Reads outside the window leave data untouched
      push(32'h0000_5A5A);
      rd(REG_STATUS, 32'h0000_0001, "status_one");
      bus.user_rden = 1'b1;
      bus.user_addr = waddr(4);
      @(negedge clk);
      bus.user_addr = 32'h0;
      @(negedge clk);
      chk("outside_rd_hit_hi", 32'(bus.rd_hit), 32'h0);
      chk("outside_rd_data_hi", bus.user_rd_data, 32'h0000_0001);
      bus.user_rden = 1'b0;
      @(negedge clk);
      chk("outside_rd_hit_lo", 32'(bus.rd_hit), 32'h0);
      chk("outside_rd_data_lo", bus.user_rd_data, 32'h0000_0001);
      rd(REG_DATA, 32'h0000_5A5A, "data_single");
      rd(REG_DATA, 32'h0000_0000, "data_empty_again");

      // Write and read CTRL in the same cycle: read sees the old value
      bus.user_wren    = 1'b1;
      bus.user_wr_data = 32'h1;
      bus.user_wstrb   = 4'h1;
      rd(REG_CTRL, 32'h0000_0000, "ctrl_rw_same_cycle");
      bus.user_wren = 1'b0;
      rd(REG_CTRL, 32'h0000_0001, "ctrl_after_rw");

      // Reset in the middle of a burst
      for (int i = 0; i < 7; i++) push(32'h300 + 32'(i));
      chk("irq_before_reset", 32'(bus.user_irq), 32'h1);
      bus.user_rden = 1'b1;
      bus.user_addr = waddr(REG_STATUS);
      bus.ev_valid  = 1'b1;
      bus.ev_data   = 32'h0000_0BAD;
      #2 rst_n = 1'b0;
      #1;
      chk("irq_in_reset",      32'(bus.user_irq), 32'h0);
      chk("ev_ready_in_reset", 32'(bus.ev_ready), 32'h1);
      chk("rd_hit_in_reset",   32'(bus.rd_hit), 32'h0);
      @(negedge clk);
      bus.user_rden = 1'b0;
      bus.ev_valid  = 1'b0;
      rst_n         = 1'b1;
      @(negedge clk);
      rd(REG_STATUS, 32'h0001_0000, "status_after_reset");

      repeat (3) @(negedge clk);
      chk("pending_reads", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
